// File: rtl/cdc_handshake_tx.sv
// cdc_handshake_tx: launching end of a 4-phase req/ack crossing, clocked by clk1.
// Optional request timeout is compiled in when CDC_TX_TIMEOUT_EN is defined.
//
// state   | meaning
// IDLE    | waiting for a word; ready only while synchronized ack is low
// REQ     | req_out high, data_out frozen, waiting for ack_sync high
// ACK_LOW | req_out low, data_out frozen, waiting for ack_sync low

module cdc_handshake_tx #(
  parameter int DATA_W         = 8,
  parameter int SYNC_STAGES    = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clk1,
  input  logic              rst,
  input  logic              src_valid,
  input  logic [DATA_W-1:0] src_data,
  output logic              src_ready,
  output logic              req_out,
  output logic [DATA_W-1:0] data_out,
  input  logic              ack_in,
  output logic              tx_done,
  output logic              timeout_err
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    ACK_LOW = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] ack_ff;
  logic                   ack_sync;
  logic                   req_d;
  logic [DATA_W-1:0]      data_d;
  logic                   tx_done_d;

  assign ack_sync  = ack_ff[SYNC_STAGES-1];
  // Blocking on tx_done keeps completion and the next acceptance in separate cycles.
  assign src_ready = (state_q == IDLE) && !ack_sync && !tx_done;

  always_ff @(posedge clk1) begin
    if (rst) begin
      ack_ff   <= '0;
      state_q  <= IDLE;
      req_out  <= 1'b0;
      data_out <= '0;
      tx_done  <= 1'b0;
    end else begin
      ack_ff   <= {ack_ff[SYNC_STAGES-2:0], ack_in};
      state_q  <= state_d;
      req_out  <= req_d;
      data_out <= data_d;
      tx_done  <= tx_done_d;
    end
  end

`ifdef CDC_TX_TIMEOUT_EN
  localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             abort_q, abort_d;
  logic             timeout_d;

  // abort_q suppresses tx_done for a word whose request was abandoned.
  always_ff @(posedge clk1) begin
    if (rst) begin
      cnt_q       <= '0;
      abort_q     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      abort_q     <= abort_d;
      timeout_err <= timeout_d;
    end
  end
`else
  assign timeout_err = 1'b0;
`endif

  always_comb begin
    state_d   = state_q;
    req_d     = req_out;
    data_d    = data_out;
    tx_done_d = 1'b0;
`ifdef CDC_TX_TIMEOUT_EN
    cnt_d     = cnt_q;
    abort_d   = abort_q;
    timeout_d = 1'b0;
`endif
    case (state_q)
      IDLE: begin
        if (src_valid && src_ready) begin
          data_d  = src_data;
          req_d   = 1'b1;
          state_d = REQ;
`ifdef CDC_TX_TIMEOUT_EN
          cnt_d   = '0;
          abort_d = 1'b0;
`endif
        end
      end
      REQ: begin
        if (ack_sync) begin
          req_d   = 1'b0;
          state_d = ACK_LOW;
        end
`ifdef CDC_TX_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          req_d     = 1'b0;
          timeout_d = 1'b1;
          abort_d   = 1'b1;
          state_d   = ACK_LOW;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ACK_LOW: begin
        if (!ack_sync) begin
          state_d = IDLE;
`ifdef CDC_TX_TIMEOUT_EN
          tx_done_d = !abort_q;
`else
          tx_done_d = 1'b1;
`endif
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cdc_handshake_tx.sv
// tb_cdc_handshake_tx: scoreboard bench for cdc_handshake_tx with a modelled clk2 receiver.
// The timeout scenario is included when CDC_TX_TIMEOUT_EN is defined.

module tb_cdc_handshake_tx;

  logic       clk1;
  logic       rst;
  logic       src_valid;
  logic [7:0] src_data;
  logic       src_ready;
  logic       req_out;
  logic [7:0] data_out;
  logic       ack_in;
  logic       tx_done;
  logic       timeout_err;

  logic ack_resp, ack_spur, resp_en;
  assign ack_in = ack_resp | ack_spur;

  int n_checks = 0;
  int n_err    = 0;
  int n_done   = 0;
  int exp_done = 0;
  int exp_to   = 0;
  logic [7:0] exp_q[$];

  cdc_handshake_tx #(
    .DATA_W(8),
    .SYNC_STAGES(2),
    .TIMEOUT_CYCLES(8)
  ) dut (
    .clk1(clk1),
    .rst(rst),
    .src_valid(src_valid),
    .src_data(src_data),
    .src_ready(src_ready),
    .req_out(req_out),
    .data_out(data_out),
    .ack_in(ack_in),
    .tx_done(tx_done),
    .timeout_err(timeout_err)
  );

  initial clk1 = 1'b0;
  always #5 clk1 = ~clk1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    n_checks++;
    n_err++;
    $display("FAIL %s: event got 1 expected 0", name);
  endtask

  // clk2-side receiver: ack follows req_out by 7 ns in both directions
  initial begin
    ack_resp = 1'b0;
    forever begin
      @(posedge req_out);
      if (resp_en) begin
        #7 ack_resp = 1'b1;
        @(negedge req_out);
        #7 ack_resp = 1'b0;
      end
    end
  end

  // Monitor: pops expected words on each new request, tracks completion pulses.
  initial begin
    logic       req_prev, busy;
    logic [7:0] cur, e;
    req_prev = 1'b0;
    busy     = 1'b0;
    cur      = '0;
    forever begin
      @(negedge clk1);
      if (rst) begin
        busy = 1'b0;
      end else begin
        if (req_out && !req_prev) begin
          if (exp_q.size() == 0) flag("unexpected_req");
          else begin
            e = exp_q.pop_front();
            chk("capture_data", data_out, e);
          end
          cur  = data_out;
          busy = 1'b1;
        end else if (busy) begin
          chk("data_hold", data_out, cur);
        end
        if (tx_done) begin
          chk("txdone_ready", src_ready, 0);
          chk("txdone_busy", busy, 1);
          if (exp_done == 0) flag("unexpected_tx_done");
          else exp_done--;
          n_done++;
          busy = 1'b0;
        end
`ifdef CDC_TX_TIMEOUT_EN
        if (timeout_err) begin
          if (exp_to == 0) flag("unexpected_timeout");
          else exp_to--;
          busy = 1'b0;
        end
`else
        chk("timeout_tied", timeout_err, 0);
`endif
      end
      req_prev = req_out;
    end
  end

  task automatic wait_req();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk1);
      if (req_out) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag("req_wait_expired");
  endtask

  task automatic wait_done(output int req_cyc);
    bit ok;
    ok      = 1'b0;
    req_cyc = 0;
    for (int i = 0; i < 80; i++) begin
      @(negedge clk1);
      if (req_out) req_cyc++;
      if (tx_done) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) flag("tx_done_wait_expired");
  endtask

  task automatic send(input logic [7:0] d, input bit expect_done);
    @(posedge clk1);
    #1;
    src_valid = 1'b1;
    src_data  = d;
    exp_q.push_back(d);
    if (expect_done) exp_done++;
    @(posedge clk1);
    #1;
    src_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got time-limit expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int rc;
    rst       = 1'b1;
    src_valid = 1'b0;
    src_data  = '0;
    ack_spur  = 1'b0;
    resp_en   = 1'b1;
    repeat (2) @(posedge clk1);
    #1 rst = 1'b0;

    @(negedge clk1);
    chk("rst_req", req_out, 0);
    chk("rst_data", data_out, 8'h00);
    chk("rst_ready", src_ready, 1);
    chk("rst_txdone", tx_done, 0);
    chk("rst_timeout", timeout_err, 0);

    // single transfer
    send(8'hA5, 1'b1);
    chk("accept_req", req_out, 1);
    chk("accept_data", data_out, 8'hA5);
    wait_done(rc);
    chk("req_high_cycles", rc, 3);

    // back-pressure: 8'h22 offered throughout the 8'h11 handshake
    @(posedge clk1);
    #1;
    src_valid = 1'b1;
    src_data  = 8'h11;
    exp_q.push_back(8'h11);
    exp_done++;
    wait_req();
    @(posedge clk1);
    #1;
    src_data = 8'h22;
    exp_q.push_back(8'h22);
    exp_done++;
    wait_done(rc);
    chk("bp_done_req", req_out, 0);
    @(negedge clk1);
    chk("bp_ready_after", src_ready, 1);
    chk("bp_req_after", req_out, 0);
    chk("bp_data_kept", data_out, 8'h11);
    @(negedge clk1);
    chk("bp_capture_req", req_out, 1);
    chk("bp_capture_data", data_out, 8'h22);
    @(posedge clk1);
    #1 src_valid = 1'b0;
    wait_done(rc);

    // spurious 25 ns ack pulse in IDLE
    @(posedge clk1);
    #1 ack_spur = 1'b1;
    @(negedge clk1);
    chk("spur_ready0", src_ready, 1);
    @(negedge clk1);
    chk("spur_ready1", src_ready, 1);
    @(negedge clk1);
    chk("spur_ready2", src_ready, 0);
    #1 ack_spur = 1'b0;
    @(negedge clk1);
    chk("spur_ready3", src_ready, 0);
    chk("spur_req", req_out, 0);
    @(negedge clk1);
    chk("spur_ready4", src_ready, 1);
    chk("spur_req_end", req_out, 0);

    // reset while req_out is high
    send(8'h5A, 1'b0);
    wait_req();
    @(posedge clk1);
    #1 rst = 1'b1;
    @(posedge clk1);
    #1 rst = 1'b0;
    @(negedge clk1);
    chk("midrst_req", req_out, 0);
    chk("midrst_data", data_out, 8'h00);
    repeat (3) @(negedge clk1);
    chk("midrst_ready", src_ready, 1);

    // recovery transfer
    send(8'h3C, 1'b1);
    wait_done(rc);

`ifdef CDC_TX_TIMEOUT_EN
    resp_en = 1'b0;
    exp_to++;
    send(8'h77, 1'b0);
    rc = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk1);
      if (!req_out) break;
      rc++;
    end
    chk("to_req_cycles", rc, 8);
    chk("to_pulse", timeout_err, 1);
    chk("to_no_done", tx_done, 0);
    chk("to_ready_busy", src_ready, 0);
    @(negedge clk1);
    chk("to_ready_again", src_ready, 1);
    chk("to_pulse_end", timeout_err, 0);
    chk("to_no_done2", tx_done, 0);
    resp_en = 1'b1;
`endif

    repeat (10) @(negedge clk1);
    chk("exp_q_empty", exp_q.size(), 0);
    chk("exp_done_left", exp_done, 0);
    chk("exp_to_left", exp_to, 0);
    chk("done_count", n_done, 4);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
